reg_dump_reader: RTL and testbench
==================================

# reg_dump_reader

- Sequential read-side master for the 32 × 32-bit register file.
- On command, it walks an inclusive address range through one read port and latches each word.
- It then streams each word out as four bytes, least-significant byte first, on a valid/ready byte interface.
- The byte stream feeds the LED/byte display path or a serial transmitter. This replaces manual selection of address, port and CS.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 entries)
- DATA_W, 32, register word width; must equal 4 × BYTE_W
- BYTE_W, 8, output byte width

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin a dump; sampled only in IDLE
- Abort  in  1  terminate current dump; no Done is generated
- First_Addr  in  ADDR_W  first register address; sampled with Start
- Last_Addr  in  ADDR_W  last register address, inclusive; sampled with Start
- Rd_Addr  out  ADDR_W  read address to the register file read port (registered)
- Rd_Data  in  DATA_W  combinational read data from the register file
- Byte_Out  out  BYTE_W  current output byte
- Byte_Valid  out  1  Byte_Out is valid
- Byte_Ready  in  1  consumer accepts the byte on a rising edge where Valid & Ready
- Byte_Idx  out  2  byte lane of Byte_Out within the word (0 = bits 7:0)
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse after the last byte of the last word is accepted

## Operation
States:
- **IDLE**
  - Start=1 latches Last_Addr into last_q.
  - Sets Rd_Addr←First_Addr and moves to FETCH.
- **FETCH**
  - word_q←Rd_Data and Byte_Idx←0.
  - Moves to SEND.
- **SEND**
  - Byte_Valid=1 and Byte_Out=word_q[8·Byte_Idx +: 8].
  - On accept with Byte_Idx<3: Byte_Idx increments.
  - On accept with Byte_Idx=3 and Rd_Addr==last_q: moves to DONE.
  - On accept with Byte_Idx=3 otherwise: Rd_Addr←Rd_Addr+1 (mod 32) and moves to FETCH.
- **DONE**
  - Done=1 for this cycle only, then moves to IDLE.

Rules:
- **Range:**
  - Word count = ((last_q − First_Addr) mod 32) + 1.
  - First_Addr > Last_Addr wraps 31→0.
  - First_Addr == Last_Addr dumps exactly one word.
- **Start:** ignored while Busy. A Start in the same cycle as DONE is not honoured; it is sampled again once in IDLE.
- **Abort:**
  - In FETCH, SEND or DONE: moves to IDLE on the next edge.
  - Byte_Valid and Done go low. Rd_Addr holds.
  - Abort has priority over the accept and over Done.
  - Abort in IDLE has no effect.
- **Coherency:**
  - Each word is a snapshot taken in FETCH.
  - Register writes after that FETCH do not appear in the stream.
  - A write to a later address is seen when that address is fetched.
- **Handshake:**
  - While Byte_Valid & !Byte_Ready, Byte_Out and Byte_Idx hold stable.
  - Byte_Valid never drops without an accept, except on Abort or Reset.

## Timing
- All outputs are driven from registers or from registered word_q/Byte_Idx. There is no combinational path from Byte_Ready or Rd_Data to any output.
- Reset values:
  - State IDLE.
  - Rd_Addr=0, word_q=0, Byte_Out=0, Byte_Idx=0.
  - Byte_Valid=0, Busy=0, Done=0.
- Reset mid-dump returns to IDLE immediately (asynchronous). Partial-word state is discarded.
- Latency:
  - Start at edge k → Busy=1 and Rd_Addr=First_Addr after edge k.
  - FETCH at edge k+1 → first Byte_Valid after edge k+1.
- Throughput:
  - With Byte_Ready held at 1, each word takes 5 cycles (1 FETCH + 4 SEND).
  - An N-word dump completes with Done at cycle k+1+5N.
- Rd_Data must be settled one cycle after Rd_Addr changes. The register file's combinational read port satisfies this.

## Structure
- Shared package `regdump_pkg`:
  - State enumeration (IDLE, FETCH, SEND, DONE).
  - ADDR_W, DATA_W, BYTE_W constants.
  - BYTES_PER_WORD = DATA_W/BYTE_W.
- Single module; no sub-module is required. The byte-lane mux is inline.
- The integration top instantiates this block beside the existing register file. Rd_Addr drives one read address port and Rd_Data takes that port's data.

## Test plan
- **Single word, Ready=1:** after Reset, write 32'h1234_5678 to reg 0; Start with First=Last=0 → bytes 78,56,34,12 with Byte_Idx 0..3 on consecutive cycles; Done pulse 1 cycle after the last accept; Busy low next cycle.
- **Wrapped range:** reg 30=32'h89AB_CDEF, reg 31=32'h7FFF_FFFF, reg 0=32'hFFFF_FFFF; First=30, Last=0 → 12 bytes EF,CD,AB,89,FF,FF,FF,7F,FF,FF,FF,FF; Rd_Addr sequence 30,31,0.
- **Backpressure:** random Byte_Ready toggling → Byte_Out and Byte_Idx are stable while Valid & !Ready; no byte is lost or duplicated; byte count = 4 × words.
- **Abort:** assert Abort during byte 2 of word 3 of a 32-word dump → IDLE on next edge, Byte_Valid=0, no Done; a new Start works normally.
- **Reset mid-operation:** assert Reset during SEND → all outputs return to reset values asynchronously; Start is ignored while Reset is high.
- **Snapshot:** write reg 5 to 32'hFFFF_FFFF while word 5 is in SEND (previous value 32'h1234_5678) → stream still shows 78,56,34,12.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared definitions for the register-dump reader.
//   ADDR_W / DATA_W / BYTE_W : default widths of the 32 x 32-bit register file
//                              and of the byte stream
//   BYTES_PER_WORD           : byte lanes per register word
//   state_t                  : dump sequencer states
package regdump_pkg;

    localparam int ADDR_W         = 5;
    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
// Walks an inclusive (wrapping) register address range through one read port
// of the register file, snapshots each word, and streams it out as bytes,
// least-significant byte first, over a valid/ready interface.
//
// Ports:
//   clk, Reset            clock, asynchronous active-high reset
//   Start                 begin a dump (only honoured in IDLE)
//   Abort                 cancel the current dump, no Done
//   First_Addr, Last_Addr inclusive address range, sampled with Start
//   Rd_Addr / Rd_Data     register file read port (address registered,
//                         data combinational from the register file)
//   Byte_Out, Byte_Idx    current byte and its lane within the word
//   Byte_Valid/Byte_Ready byte handshake
//   Busy                  high whenever not IDLE
//   Done                  one-cycle pulse after the final byte is accepted
module reg_dump_reader #(
    parameter int ADDR_W = regdump_pkg::ADDR_W,
    parameter int DATA_W = regdump_pkg::DATA_W,
    parameter int BYTE_W = regdump_pkg::BYTE_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] First_Addr,
    input  logic [ADDR_W-1:0] Last_Addr,
    output logic [ADDR_W-1:0] Rd_Addr,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic [BYTE_W-1:0] Byte_Out,
    output logic              Byte_Valid,
    input  logic              Byte_Ready,
    output logic [1:0]        Byte_Idx,
    output logic              Busy,
    output logic              Done
);
    import regdump_pkg::*;

    localparam int         LANES     = DATA_W / BYTE_W;
    localparam logic [1:0] LAST_LANE = 2'(LANES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic                byte_valid_q, byte_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        last_d     = last_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    last_d    = Last_Addr;
                    rd_addr_d = First_Addr;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                // Snapshot: later writes to this register never reach the stream.
                word_d     = Rd_Data;
                byte_idx_d = 2'd0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (Byte_Ready) begin
                    if (byte_idx_q != LAST_LANE) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else if (rd_addr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Natural ADDR_W-bit overflow gives the 31 -> 0 wrap.
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any accept or Done; address and lane index hold.
        if (Abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            rd_addr_d  = rd_addr_q;
            byte_idx_d = byte_idx_q;
            word_d     = word_q;
        end

        // Status outputs are registered decodes of the next state, so they
        // line up exactly with the state they describe.
        busy_d       = (state_d != S_IDLE);
        byte_valid_d = (state_d == S_SEND);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            last_q       <= '0;
            word_q       <= '0;
            byte_idx_q   <= 2'd0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            last_q       <= last_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Byte-lane mux: driven only from registered word_q and byte_idx_q.
    logic [BYTE_W-1:0] lane [LANES];
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane[gi] = word_q[gi*BYTE_W +: BYTE_W];
    end

    assign Byte_Out   = lane[byte_idx_q];
    assign Byte_Idx   = byte_idx_q;
    assign Byte_Valid = byte_valid_q;
    assign Rd_Addr    = rd_addr_q;
    assign Busy       = busy_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: a behavioural 32 x 32 register file feeds the
// read port; a table of dump vectors is streamed and every byte, lane index
// and read address is compared against hand-computed values, followed by
// hand-written Abort and mid-dump Reset sequences.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Abort;
    logic [4:0]  First_Addr;
    logic [4:0]  Last_Addr;
    logic [4:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic [7:0]  Byte_Out;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic [1:0]  Byte_Idx;
    logic        Busy;
    logic        Done;

    logic [31:0] regs [32];
    assign Rd_Data = regs[Rd_Addr];

    always #5 clk = ~clk;

    reg_dump_reader dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .Abort      (Abort),
        .First_Addr (First_Addr),
        .Last_Addr  (Last_Addr),
        .Rd_Addr    (Rd_Addr),
        .Rd_Data    (Rd_Data),
        .Byte_Out   (Byte_Out),
        .Byte_Valid (Byte_Valid),
        .Byte_Ready (Byte_Ready),
        .Byte_Idx   (Byte_Idx),
        .Busy       (Busy),
        .Done       (Done)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue Start at a negedge; check Busy/Rd_Addr right after the sampling edge.
    task automatic start_dump(input logic [4:0] first, input logic [4:0] last);
        @(negedge clk);
        First_Addr = first;
        Last_Addr  = last;
        Start      = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("start_busy", 32'(Busy), 32'd1);
        chk("start_rd_addr", 32'(Rd_Addr), 32'(first));
        chk("fetch_no_valid", 32'(Byte_Valid), 32'd0);
    endtask

    // Consume nbytes bytes; exp holds words packed LSB-first, addrs 5 bits per word.
    task automatic stream(input int nbytes, input logic [159:0] exp, input logic [24:0] addrs,
                          input bit rnd, input bit mid_en, input logic [4:0] mid_addr,
                          input logic [31:0] mid_data);
        int  cnt = 0;
        bit  early_done = 0;
        bit  wrote = 0;
        logic rdy;
        logic [7:0] eb;
        logic [4:0] ea;
        for (int cyc = 0; cyc < 400 && cnt < nbytes; cyc++) begin
            @(negedge clk);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            Byte_Ready = rdy;
            if (Done) early_done = 1;
            if (Byte_Valid) begin
                if (mid_en && !wrote) begin
                    regs[mid_addr] = mid_data;
                    wrote = 1;
                end
                eb = exp[cnt*8 +: 8];
                ea = addrs[(cnt/4)*5 +: 5];
                chk($sformatf("byte%0d_out", cnt), 32'(Byte_Out), 32'(eb));
                chk($sformatf("byte%0d_idx", cnt), 32'(Byte_Idx), 32'(cnt % 4));
                chk($sformatf("byte%0d_rd_addr", cnt), 32'(Rd_Addr), 32'(ea));
                if (rdy) cnt++;
            end
        end
        chk("byte_count", 32'(cnt), 32'(nbytes));
        chk("no_early_done", 32'(early_done), 32'd0);
        @(negedge clk);
        Byte_Ready = 1'b0;
        chk("done_pulse", 32'(Done), 32'd1);
        chk("done_valid_low", 32'(Byte_Valid), 32'd0);
        // A Start coinciding with DONE must not be honoured.
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("done_cleared", 32'(Done), 32'd0);
        chk("idle_after_done", 32'(Busy), 32'd0);
    endtask

    typedef struct {
        logic         pre_en;
        logic [4:0]   pre_addr;
        logic [31:0]  pre_data;
        logic         mid_en;
        logic [4:0]   mid_addr;
        logic [31:0]  mid_data;
        logic [4:0]   first;
        logic [4:0]   last;
        int           nbytes;
        bit           rnd;
        logic [159:0] exp;
        logic [24:0]  addrs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Byte_Ready = 1'b0;
        First_Addr = '0; Last_Addr = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[0]  = 32'h1234_5678;
        regs[1]  = 32'hCAFE_BABE;
        regs[2]  = 32'hDEAD_BEEF;
        regs[6]  = 32'h0BAD_F00D;
        regs[30] = 32'h89AB_CDEF;
        regs[31] = 32'h7FFF_FFFF;

        // single word at reg 0
        vecs[0] = '{0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 4, 0,
                    160'h1234_5678, 25'd0};
        // wrapped range 30..0 after reg 0 <- FFFFFFFF
        vecs[1] = '{1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 5'd30, 5'd0, 12, 0,
                    {64'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h89AB_CDEF},
                    {10'd0, 5'd0, 5'd31, 5'd30}};
        // plain two-word range
        vecs[2] = '{0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 8, 0,
                    {96'h0, 32'hDEAD_BEEF, 32'hCAFE_BABE},
                    {15'd0, 5'd2, 5'd1}};
        // single word at the top address
        vecs[3] = '{0, 0, 0, 0, 0, 0, 5'd31, 5'd31, 4, 0,
                    160'h7FFF_FFFF, 25'd31};
        // five-word wrapped range with random backpressure
        vecs[4] = '{0, 0, 0, 0, 0, 0, 5'd30, 5'd2, 20, 1,
                    {32'hDEAD_BEEF, 32'hCAFE_BABE, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h89AB_CDEF},
                    {5'd2, 5'd1, 5'd0, 5'd31, 5'd30}};
        // snapshot: reg 5 overwritten while its word is being sent
        vecs[5] = '{1, 5'd5, 32'h1234_5678, 1, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd6, 8, 1,
                    {96'h0, 32'h0BAD_F00D, 32'h1234_5678},
                    {15'd0, 5'd6, 5'd5}};

        repeat (2) @(negedge clk);
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(Byte_Valid), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_rd_addr", 32'(Rd_Addr), 32'd0);
        chk("rst_byte_out", 32'(Byte_Out), 32'd0);
        chk("rst_byte_idx", 32'(Byte_Idx), 32'd0);
        Reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pre_en) regs[vecs[v].pre_addr] = vecs[v].pre_data;
            start_dump(vecs[v].first, vecs[v].last);
            stream(vecs[v].nbytes, vecs[v].exp, vecs[v].addrs, vecs[v].rnd,
                   vecs[v].mid_en, vecs[v].mid_addr, vecs[v].mid_data);
            $display("vector %0d: range %0d..%0d, %0d bytes, miscompares so far %0d",
                     v, vecs[v].first, vecs[v].last, vecs[v].nbytes, n_bad);
        end

        // Abort during byte 2 of word 3 (address 2) of a 32-word dump.
        begin
            bit found = 0;
            bit saw_done = 0;
            start_dump(5'd0, 5'd31);
            for (int c = 0; c < 100 && !found; c++) begin
                @(negedge clk);
                Byte_Ready = 1'b1;
                if (Byte_Valid && Rd_Addr == 5'd2 && Byte_Idx == 2'd2) found = 1;
            end
            chk("abort_point_reached", 32'(found), 32'd1);
            Abort = 1'b1;
            @(negedge clk);
            Abort = 1'b0;
            Byte_Ready = 1'b0;
            chk("abort_valid", 32'(Byte_Valid), 32'd0);
            chk("abort_busy", 32'(Busy), 32'd0);
            chk("abort_done", 32'(Done), 32'd0);
            chk("abort_rd_addr_hold", 32'(Rd_Addr), 32'd2);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (Done || Busy) saw_done = 1;
            end
            chk("abort_stays_idle", 32'(saw_done), 32'd0);
            $display("abort sequence: miscompares so far %0d", n_bad);
            start_dump(5'd1, 5'd1);
            stream(4, 160'hCAFE_BABE, 25'd1, 0, 0, 5'd0, 32'h0);
            $display("restart after abort: miscompares so far %0d", n_bad);
        end

        // Asynchronous Reset while in SEND; Start ignored while Reset is high.
        begin
            bit found = 0;
            start_dump(5'd2, 5'd2);
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                Byte_Ready = 1'b0;
                if (Byte_Valid) found = 1;
            end
            chk("reset_in_send", 32'(found), 32'd1);
            #2 Reset = 1'b1;
            #1;
            chk("arst_valid", 32'(Byte_Valid), 32'd0);
            chk("arst_busy", 32'(Busy), 32'd0);
            chk("arst_rd_addr", 32'(Rd_Addr), 32'd0);
            chk("arst_byte_out", 32'(Byte_Out), 32'd0);
            chk("arst_byte_idx", 32'(Byte_Idx), 32'd0);
            chk("arst_done", 32'(Done), 32'd0);
            Start = 1'b1;
            @(negedge clk);
            chk("start_during_reset", 32'(Busy), 32'd0);
            Start = 1'b0;
            Reset = 1'b0;
            @(negedge clk);
            chk("idle_after_reset", 32'(Busy), 32'd0);
            $display("reset sequence: miscompares so far %0d", n_bad);
            start_dump(5'd2, 5'd2);
            stream(4, 160'hDEAD_BEEF, 25'd2, 0, 0, 5'd0, 32'h0);
            $display("restart after reset: miscompares so far %0d", n_bad);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
